mem_stage_ctrl: RTL and testbench

- Memory-stage controller of the 5-stage 16-bit pipeline.
- Consumes the execute-to-memory pipeline register outputs and performs data-memory accesses over a req/ack handshake.
- Sequences load-multiple/store-multiple (LM/SM) register-mask transfers.
- Drives the memory-to-writeback bundle, plus a stall that freezes the execute-to-memory register and upstream stages.

---
 rtl/mem_stage_ctrl_pkg.sv | 30 +++
 rtl/mem_stage_ctrl_prio_enc8.sv | 20 ++
 rtl/mem_stage_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the memory-stage controller.
package mem_stage_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 8;
    localparam int unsigned CW_W   = 8;
    localparam int unsigned MASK_W = NREG;
    localparam int unsigned REG_AW = $clog2(NREG);

    localparam int unsigned CW_MEM_RD = 0;
    localparam int unsigned CW_MEM_WR = 1;
    localparam int unsigned CW_REG_WR = 2;
    localparam int unsigned CW_MULTI  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MULTI  = 2'd2
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [CW_W-1:0]   cw;
        logic [DATA_W-1:0] res;
        logic [REG_AW-1:0] dest;
    } wb_bundle_t;

endpackage

// File: rtl/mem_stage_ctrl_prio_enc8.sv
// Lowest-set-bit encoder for LM/SM register selection.
module prio_enc8
    import mem_stage_ctrl_pkg::*;
(
    input  logic [MASK_W-1:0] vec_i,
    output logic [REG_AW-1:0] idx_o,
    output logic              any_o
);

    // Scan downward so the lowest set bit wins.
    always_comb begin
        idx_o = '0;
        for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = REG_AW'(i);
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: single loads/stores and LM/SM sequencing over a req/ack port,
// producing the M2W bundle and the upstream stall.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] pc_mem_16,
    input  logic [DATA_W-1:0] instr_mem_16,
    input  logic [CW_W-1:0]   cw_mem_8,
    input  logic [DATA_W-1:0] in_mem_16,
    input  logic [DATA_W-1:0] ra_mem_16,
    input  logic [REG_AW-1:0] dest_mem_3,
    output logic              stall_o,
    output logic [REG_AW-1:0] rf_raddr_3,
    input  logic [DATA_W-1:0] rf_rdata_16,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              valid_wb,
    output logic [DATA_W-1:0] pc_wb_16,
    output logic [DATA_W-1:0] instr_wb_16,
    output logic [CW_W-1:0]   cw_wb_8,
    output logic [DATA_W-1:0] res_wb_16,
    output logic [REG_AW-1:0] dest_wb_3
);

    state_e            state_q, state_d;
    logic [MASK_W-1:0] mask_q, mask_d, mask_cur, mask_rem;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [REG_AW-1:0] cur_idx;
    logic              mask_any;
    logic              mem_op, is_multi;
    wb_bundle_t        wb_q, wb_d;

    logic              req_c, we_c, stall_c;
    logic [DATA_W-1:0] addr_c, wdata_c;
    logic [REG_AW-1:0] raddr_c;

    assign mem_op   = cw_mem_8[CW_MEM_RD] | cw_mem_8[CW_MEM_WR];
    assign is_multi = mem_op & cw_mem_8[CW_MULTI];

    // First LM/SM cycle takes the mask straight from the instruction.
    assign mask_cur = (state_q == ST_MULTI) ? mask_q : instr_mem_16[MASK_W-1:0];
    assign mask_rem = mask_cur & ~(MASK_W'(1) << cur_idx);

    prio_enc8 u_prio (
        .vec_i (mask_cur),
        .idx_o (cur_idx),
        .any_o (mask_any)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
        end
    end

    always_comb begin
        state_d     = ST_IDLE;
        mask_d      = '0;
        cnt_d       = '0;
        req_c       = 1'b0;
        we_c        = 1'b0;
        addr_c      = '0;
        wdata_c     = '0;
        raddr_c     = '0;
        stall_c     = 1'b0;
        wb_d.valid  = 1'b0;
        wb_d.pc     = pc_mem_16;
        wb_d.instr  = instr_mem_16;
        wb_d.cw     = cw_mem_8;
        wb_d.res    = in_mem_16;
        wb_d.dest   = dest_mem_3;

        if (is_multi) begin
            if (!mask_any) begin
                wb_d.valid           = 1'b1;
                wb_d.cw[CW_REG_WR]   = 1'b0;
            end else begin
                req_c  = 1'b1;
                we_c   = cw_mem_8[CW_MEM_WR];
                addr_c = in_mem_16 + cnt_q;
                if (we_c) begin
                    raddr_c = cur_idx;
                    wdata_c = rf_rdata_16;
                end
                if (dmem_ack) begin
                    if (!we_c) begin
                        wb_d.valid         = 1'b1;
                        wb_d.cw[CW_REG_WR] = 1'b1;
                        wb_d.res           = dmem_rdata;
                        wb_d.dest          = cur_idx;
                    end
                    if (mask_rem != '0) begin
                        state_d = ST_MULTI;
                        mask_d  = mask_rem;
                        cnt_d   = cnt_q + DATA_W'(1);
                        stall_c = 1'b1;
                    end
                end else begin
                    state_d = ST_MULTI;
                    mask_d  = mask_cur;
                    cnt_d   = cnt_q;
                    stall_c = 1'b1;
                end
            end
        end else if (mem_op) begin
            req_c   = 1'b1;
            we_c    = cw_mem_8[CW_MEM_WR];
            addr_c  = in_mem_16;
            wdata_c = ra_mem_16;
            if (dmem_ack) begin
                wb_d.valid = 1'b1;
                wb_d.res   = we_c ? in_mem_16 : dmem_rdata;
            end else begin
                state_d = ST_ACCESS;
                stall_c = 1'b1;
            end
        end else begin
            wb_d.valid = |cw_mem_8;
        end
    end

    // Reset must silence the memory port and stall without waiting for a clock.
    assign dmem_req    = clr_n & req_c;
    assign dmem_we     = clr_n & we_c;
    assign stall_o     = clr_n & stall_c;
    assign dmem_addr   = {DATA_W{clr_n}} & addr_c;
    assign dmem_wdata  = {DATA_W{clr_n}} & wdata_c;
    assign rf_raddr_3  = {REG_AW{clr_n}} & raddr_c;

    assign valid_wb    = wb_q.valid;
    assign pc_wb_16    = wb_q.pc;
    assign instr_wb_16 = wb_q.instr;
    assign cw_wb_8     = wb_q.cw;
    assign res_wb_16   = wb_q.res;
    assign dest_wb_3   = wb_q.dest;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized instruction stream.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [15:0] pc_mem_16, instr_mem_16, in_mem_16, ra_mem_16;
    logic [7:0]  cw_mem_8;
    logic [2:0]  dest_mem_3;
    logic        stall_o;
    logic [2:0]  rf_raddr_3;
    logic [15:0] rf_rdata_16;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        valid_wb;
    logic [15:0] pc_wb_16, instr_wb_16, res_wb_16;
    logic [7:0]  cw_wb_8;
    logic [2:0]  dest_wb_3;

    logic [15:0] rf [8];
    assign rf_rdata_16 = rf[rf_raddr_3];

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk(clk), .clr_n(clr_n),
        .pc_mem_16(pc_mem_16), .instr_mem_16(instr_mem_16), .cw_mem_8(cw_mem_8),
        .in_mem_16(in_mem_16), .ra_mem_16(ra_mem_16), .dest_mem_3(dest_mem_3),
        .stall_o(stall_o), .rf_raddr_3(rf_raddr_3), .rf_rdata_16(rf_rdata_16),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .valid_wb(valid_wb), .pc_wb_16(pc_wb_16), .instr_wb_16(instr_wb_16),
        .cw_wb_8(cw_wb_8), .res_wb_16(res_wb_16), .dest_wb_3(dest_wb_3)
    );

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [2:0]  raddr;
        logic [2:0]  dest;
    } beat_t;

    typedef struct {
        logic        valid;
        logic [15:0] pc, instr, res;
        logic [7:0]  cw;
        logic [2:0]  dest;
    } wb_t;

    int total = 0;
    int bad   = 0;
    wb_t exp_wb;
    logic        fix_rd_en = 1'b0;
    logic [15:0] fix_rd = '0;

    logic [15:0] xfer_addr[$];
    logic [2:0]  xfer_raddr[$];
    logic [15:0] wb_res[$];
    logic [2:0]  wb_dest[$];
    logic [7:0]  wb_cw[$];
    int          stall_cnt;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void clear_logs();
        xfer_addr.delete(); xfer_raddr.delete();
        wb_res.delete(); wb_dest.delete(); wb_cw.delete();
        stall_cnt = 0;
    endfunction

    task automatic check_wb();
        chk("wb_valid", 32'(valid_wb), 32'(exp_wb.valid));
        if (valid_wb) begin
            wb_res.push_back(res_wb_16);
            wb_dest.push_back(dest_wb_3);
            wb_cw.push_back(cw_wb_8);
        end
        if (exp_wb.valid) begin
            chk("wb_res",   32'(res_wb_16),   32'(exp_wb.res));
            chk("wb_dest",  32'(dest_wb_3),   32'(exp_wb.dest));
            chk("wb_cw",    32'(cw_wb_8),     32'(exp_wb.cw));
            chk("wb_pc",    32'(pc_wb_16),    32'(exp_wb.pc));
            chk("wb_instr", 32'(instr_wb_16), 32'(exp_wb.instr));
        end
    endtask

    // Present one instruction and hold it until the model says it retires.
    // ack_delay < 0: random ack; otherwise ack after ack_delay waiting cycles per beat.
    task automatic do_instr(input logic [15:0] pc, input logic [15:0] instr, input logic [7:0] cw,
                            input logic [15:0] in_mem, input logic [15:0] ra, input logic [2:0] dest,
                            input int ack_delay, input int abort_after);
        beat_t q[$];
        beat_t b;
        logic  mem_op, multi, ack, exp_stall;
        logic [15:0] rdata;
        int k, wait_cnt, cyc, nx;

        mem_op = cw[0] | cw[1];
        multi  = mem_op & cw[3];
        if (multi) begin
            k = 0;
            for (int i = 0; i < 8; i++) begin
                if (instr[i]) begin
                    b.addr  = in_mem + 16'(k);
                    b.we    = cw[1];
                    b.wdata = rf[i];
                    b.raddr = cw[1] ? 3'(i) : 3'd0;
                    b.dest  = 3'(i);
                    q.push_back(b);
                    k++;
                end
            end
        end else if (mem_op) begin
            b.addr = in_mem; b.we = cw[1]; b.wdata = ra; b.raddr = 3'd0; b.dest = dest;
            q.push_back(b);
        end

        pc_mem_16 = pc; instr_mem_16 = instr; cw_mem_8 = cw;
        in_mem_16 = in_mem; ra_mem_16 = ra; dest_mem_3 = dest;
        wait_cnt = 0; cyc = 0; nx = 0;

        forever begin
            ack   = (ack_delay < 0) ? 1'($urandom_range(0, 1)) : (wait_cnt == ack_delay);
            rdata = fix_rd_en ? fix_rd : 16'($urandom);
            dmem_ack = ack; dmem_rdata = rdata;
            @(negedge clk);
            check_wb();
            if (stall_o) stall_cnt++;
            exp_wb.pc = pc; exp_wb.instr = instr;
            if (q.size() > 0) begin
                b = q[0];
                chk("req",   32'(dmem_req),   32'd1);
                chk("addr",  32'(dmem_addr),  32'(b.addr));
                chk("we",    32'(dmem_we),    32'(b.we));
                chk("raddr", 32'(rf_raddr_3), 32'(b.raddr));
                if (b.we) chk("wdata", 32'(dmem_wdata), 32'(b.wdata));
                exp_wb.valid = 1'b0;
                if (ack) begin
                    xfer_addr.push_back(dmem_addr);
                    xfer_raddr.push_back(rf_raddr_3);
                    void'(q.pop_front());
                    nx++;
                    wait_cnt = 0;
                    if (multi) begin
                        exp_wb.valid = ~cw[1];
                        exp_wb.res   = rdata;
                        exp_wb.dest  = b.dest;
                        exp_wb.cw    = cw | 8'h04;
                    end else begin
                        exp_wb.valid = 1'b1;
                        exp_wb.res   = cw[1] ? in_mem : rdata;
                        exp_wb.dest  = dest;
                        exp_wb.cw    = cw;
                    end
                end else begin
                    wait_cnt++;
                end
                exp_stall = !(ack && q.size() == 0);
            end else begin
                chk("req_idle",   32'(dmem_req),   32'd0);
                chk("raddr_idle", 32'(rf_raddr_3), 32'd0);
                exp_stall    = 1'b0;
                exp_wb.valid = (cw != 8'h00);
                exp_wb.res   = in_mem;
                exp_wb.dest  = dest;
                exp_wb.cw    = multi ? (cw & 8'hFB) : cw;
            end
            chk("stall", 32'(stall_o), 32'(exp_stall));
            @(posedge clk); #1;
            cyc++;
            if (!exp_stall) break;
            if (abort_after > 0 && nx == abort_after) break;
            if (cyc >= 400) begin
                total++; bad++;
                $display("FAIL timeout: instruction did not retire within %0d cycles", cyc);
                break;
            end
        end
    endtask

    task automatic bubble();
        do_instr(16'h0, 16'h0, 8'h00, 16'h0, 16'h0, 3'd0, 0, 0);
    endtask

    initial begin
        logic [7:0]  cw;
        logic [15:0] instr, base;
        int kind;

        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        exp_wb = '{valid: 1'b0, pc: '0, instr: '0, res: '0, cw: '0, dest: '0};
        clear_logs();

        // Reset with a pending load on the inputs: everything must read 0.
        clr_n = 1'b0;
        pc_mem_16 = 16'h0; instr_mem_16 = 16'h0; cw_mem_8 = 8'h01;
        in_mem_16 = 16'h0055; ra_mem_16 = 16'h0; dest_mem_3 = 3'd0;
        dmem_ack = 1'b1; dmem_rdata = 16'h0;
        #12;
        chk("rst_valid", 32'(valid_wb), 32'd0);
        chk("rst_stall", 32'(stall_o),  32'd0);
        chk("rst_req",   32'(dmem_req), 32'd0);
        chk("rst_addr",  32'(dmem_addr), 32'd0);
        chk("rst_res",   32'(res_wb_16), 32'd0);
        chk("rst_cw",    32'(cw_wb_8),   32'd0);
        cw_mem_8 = 8'h00;
        @(negedge clk); clr_n = 1'b1;
        @(posedge clk); #1;

        // ALU op
        clear_logs();
        do_instr(16'h0010, 16'h0000, 8'h04, 16'h1234, 16'h0, 3'd3, 0, 0);
        bubble();
        chk("alu_stall_cnt", 32'(stall_cnt),     32'd0);
        chk("alu_wb_cnt",    32'(wb_res.size()), 32'd1);
        chk("alu_res",       32'(wb_res[0]),     32'h1234);
        chk("alu_dest",      32'(wb_dest[0]),    32'd3);

        // LW with ack after 3 wait cycles
        clear_logs();
        fix_rd_en = 1'b1; fix_rd = 16'hBEEF;
        do_instr(16'h0011, 16'h0000, 8'h05, 16'h0040, 16'h0, 3'd1, 3, 0);
        fix_rd_en = 1'b0;
        bubble();
        chk("lw_stall_cnt", 32'(stall_cnt),     32'd3);
        chk("lw_addr",      32'(xfer_addr[0]),  32'h0040);
        chk("lw_res",       32'(wb_res[0]),     32'hBEEF);

        // SW with same-cycle ack
        clear_logs();
        do_instr(16'h0012, 16'h0000, 8'h02, 16'h0010, 16'hA5A5, 3'd0, 0, 0);
        bubble();
        chk("sw_stall_cnt", 32'(stall_cnt),        32'd0);
        chk("sw_beats",     32'(xfer_addr.size()), 32'd1);
        chk("sw_addr",      32'(xfer_addr[0]),     32'h0010);

        // LM mask 0x25 from 0x0100
        clear_logs();
        do_instr(16'h0013, 16'h0025, 8'h09, 16'h0100, 16'h0, 3'd0, 0, 0);
        bubble();
        chk("lm_stall_cnt", 32'(stall_cnt),     32'd2);
        chk("lm_wb_cnt",    32'(wb_res.size()), 32'd3);
        chk("lm_addr0",     32'(xfer_addr[0]),  32'h0100);
        chk("lm_addr1",     32'(xfer_addr[1]),  32'h0101);
        chk("lm_addr2",     32'(xfer_addr[2]),  32'h0102);
        chk("lm_dest0",     32'(wb_dest[0]),    32'd0);
        chk("lm_dest1",     32'(wb_dest[1]),    32'd2);
        chk("lm_dest2",     32'(wb_dest[2]),    32'd5);

        // SM mask 0x81 from 0xFFFF (address wraps)
        clear_logs();
        do_instr(16'h0014, 16'h0081, 8'h0A, 16'hFFFF, 16'h0, 3'd0, 1, 0);
        bubble();
        chk("sm_raddr0", 32'(xfer_raddr[0]), 32'd0);
        chk("sm_raddr1", 32'(xfer_raddr[1]), 32'd7);
        chk("sm_addr0",  32'(xfer_addr[0]),  32'hFFFF);
        chk("sm_addr1",  32'(xfer_addr[1]),  32'h0000);
        chk("sm_wb_cnt", 32'(wb_res.size()), 32'd0);

        // LM with empty mask: one cycle, reg_wr cleared
        clear_logs();
        do_instr(16'h0015, 16'h0000, 8'h0D, 16'h0200, 16'h0, 3'd4, 0, 0);
        bubble();
        chk("lm0_stall_cnt", 32'(stall_cnt),        32'd0);
        chk("lm0_beats",     32'(xfer_addr.size()), 32'd0);
        chk("lm0_cw",        32'(wb_cw[0]),         32'h09);

        // Reset in the middle of an LM
        clear_logs();
        do_instr(16'h0016, 16'h0025, 8'h09, 16'h0200, 16'h0, 3'd0, 0, 1);
        dmem_ack = 1'b1;
        #2 clr_n = 1'b0;
        #1;
        chk("mid_rst_req",   32'(dmem_req), 32'd0);
        chk("mid_rst_valid", 32'(valid_wb), 32'd0);
        chk("mid_rst_stall", 32'(stall_o),  32'd0);
        cw_mem_8 = 8'h00; instr_mem_16 = 16'h0;
        @(negedge clk); clr_n = 1'b1;
        exp_wb.valid = 1'b0;
        @(posedge clk); #1;
        bubble();
        clear_logs();
        do_instr(16'h0017, 16'h0003, 8'h09, 16'h0300, 16'h0, 3'd0, 0, 0);
        chk("post_rst_addr0", 32'(xfer_addr[0]), 32'h0300);
        chk("post_rst_addr1", 32'(xfer_addr[1]), 32'h0301);

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 5));
            instr = 16'($urandom);
            base  = ($urandom_range(0, 3) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7))) : 16'($urandom);
            if (kind >= 4 && $urandom_range(0, 7) == 0) instr[7:0] = 8'h00;
            case (kind)
                0: cw = 8'h00;
                1: cw = {4'($urandom), 4'b0100};
                2: cw = {4'($urandom), 1'b0, 1'($urandom), 2'b01};
                3: cw = {4'($urandom), 4'b0010};
                4: cw = {4'($urandom), 1'b1, 1'($urandom), 2'b01};
                default: cw = {4'($urandom), 4'b1010};
            endcase
            do_instr(16'($urandom), instr, cw, base, 16'($urandom), 3'($urandom),
                     ($urandom_range(0, 3) == 0) ? 0 : -1, 0);
        end
        bubble();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
